jpeg_cone_arbiter: RTL

Round-robin scheduler that time-shares a single instance of a 6-input/1-output JPEG timing cone between `NREQ` requesters. Each granted request's 6-bit operand is captured, held stable on the cone inputs for a fixed evaluation window, and the sampled 1-bit result is returned to the requester over a valid/ready response channel. It sits between the JPEG stage control logic and the shared cone instance, which is instantiated outside this block.

---
 rtl/jpeg_cone_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/jpeg_cone_arbiter.sv
// Round-robin scheduler time-sharing one external 6-in/1-out JPEG cone between NREQ requesters.
// Optional completed-transaction counter `txn_cnt` is enabled by defining JPEG_CONE_ARB_STATS_EN.
`timescale 1ns/1ps

module jpeg_cone_arbiter #(
    parameter int NREQ     = 4,
    parameter int CONE_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [6*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic                rsp_data,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [5:0]          cone_in,
    input  logic                cone_out
`ifdef JPEG_CONE_ARB_STATS_EN
    ,output logic [15:0]        txn_cnt
`endif
);

    localparam int PW = $clog2(NREQ);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $fatal(1, "jpeg_cone_arbiter: NREQ must be in 2..8");
        end
        if (CONE_LAT < 0 || CONE_LAT > 7) begin : g_bad_lat
            $fatal(1, "jpeg_cone_arbiter: CONE_LAT must be in 0..7");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [5:0]      cone_in_q, cone_in_d;
    logic            res_q, res_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
`ifdef JPEG_CONE_ARB_STATS_EN
    logic [15:0]     txn_cnt_q, txn_cnt_d;
`endif

    logic [PW-1:0]   scan_idx;
    logic [PW-1:0]   gnt_sel;
    logic            any_req;

    // Scan downward in distance from ptr so the nearest valid requester after ptr wins.
    always_comb begin
        scan_idx = '0;
        gnt_sel  = '0;
        any_req  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = PW'((int'(ptr_q) + k) % NREQ);
            if (req_valid[scan_idx]) begin
                gnt_sel = scan_idx;
                any_req = 1'b1;
            end
        end
    end

    assign req_ready = (state_q == S_IDLE && any_req) ? (NREQ'(1) << gnt_sel) : '0;

    // NOTE: every _d gets its _q as default first, so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        cone_in_d   = cone_in_q;
        res_d       = res_q;
        rsp_valid_d = rsp_valid_q;
`ifdef JPEG_CONE_ARB_STATS_EN
        txn_cnt_d   = txn_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    cone_in_d = req_data[6*gnt_sel +: 6];
                    gnt_d     = gnt_sel;
                    cnt_d     = 3'(CONE_LAT);
                    state_d   = S_EVAL;
                end
            end
            S_EVAL: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    res_d       = cone_out;
                    rsp_valid_d = NREQ'(1) << gnt_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = gnt_q;
                    state_d     = S_IDLE;
`ifdef JPEG_CONE_ARB_STATS_EN
                    txn_cnt_d   = txn_cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= PW'(NREQ - 1);
            gnt_q       <= '0;
            cnt_q       <= '0;
            cone_in_q   <= '0;
            res_q       <= 1'b0;
            rsp_valid_q <= '0;
`ifdef JPEG_CONE_ARB_STATS_EN
            txn_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            cone_in_q   <= cone_in_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef JPEG_CONE_ARB_STATS_EN
            txn_cnt_q   <= txn_cnt_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_q;
    assign cone_in   = cone_in_q;
`ifdef JPEG_CONE_ARB_STATS_EN
    assign txn_cnt   = txn_cnt_q;
`endif

endmodule
